sw_target_streamer: RTL and testbench
=====================================

Name: sw_target_streamer

Overview:
- Host-side driver for the dual-channel Smith-Waterman scoring array.
- Start-up: issues the penalty/query load strobes and waits for the array's ready flag.
- Streaming: takes 2-bit target bases from two per-channel FIFOs and time-multiplexes them onto the array's data_in/en0/en1 inputs in alternating channel slots.
- Results: captures result0/result1 on each valid rising edge and returns them, tagged by channel and sequence id, over a valid/ready result port.

Parameters:
SCORE_WIDTH, 12, width of captured scores
FIFO_DEPTH, 16, base entries per channel FIFO (power of 2, ≥2)
ID_WIDTH, 8, per-channel sequence id width
RES_DEPTH, 4, result FIFO entries (power of 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  pulse: begin configuration
ld_p  out  1  penalty load strobe to scoring array
ld_q  out  1  query load strobe to scoring array
sm_ready  in  1  scoring array ready
s_valid  in  1  base input valid
s_ready  out  1  base accepted (FIFO[s_chan] not full)
s_base  in  2  target base (A=10, G=11, T=00, C=01)
s_chan  in  1  destination channel
s_last  in  1  last base of sequence
data_out  out  2  base to array data_in
en0_out  out  1  channel-0 enable
en1_out  out  1  channel-1 enable
res0_in  in  SCORE_WIDTH  array result0
res1_in  in  SCORE_WIDTH  array result1
vld0_in  in  1  array vld0
vld1_in  in  1  array vld1
r_valid  out  1  result valid
r_ready  in  1  result accepted
r_score  out  SCORE_WIDTH  biased score
r_chan  out  1  result channel
r_id  out  ID_WIDTH  per-channel sequence id
busy  out  1  FSM not IDLE
ovf_err  out  1  sticky: FIFO full with no s_last inside
drop_err  out  1  sticky: result lost, result FIFO full

Behaviour:
- Reset (async, rst=0):
  - All registered outputs 0, FSM IDLE, phase 0, FIFOs empty, ids 0, sticky flags 0.
  - s_ready is combinational ~full[s_chan], so it reads 1 while in reset.
- FSM:
  - IDLE -start-> LOAD.
  - LOAD: ld_p=ld_q=1 for exactly one cycle -> WAIT.
  - WAIT -sm_ready-> RUN.
  - RUN is held until reset. start is ignored outside IDLE.
- Base intake: accepted in any state when s_valid&s_ready. Entry stored is {base,last}. Each channel keeps last_cnt, the count of s_last entries held in its FIFO.
- Phase: toggles every cycle in RUN, held 0 otherwise. phase==c is channel c's slot.
- Channel slot c in RUN. Outputs are registered and update the cycle after the slot:
  - Idle channel with last_cnt>0 and gap flag clear: start a sequence, pop, en_c=1, data_out=base.
  - Active channel: pop each slot. The FIFO is guaranteed non-empty because a complete sequence is resident.
  - On popping a last entry: decrement last_cnt and set gap. The next slot of c drives en_c=0 and clears gap. This gives a minimum one-slot idle between sequences.
  - en_c changes only at its own slot, so it is stable over 2-cycle periods.
  - data_out changes every cycle. It is 00 when the served channel is not enabled.
- Pops and pushes on the same FIFO in one cycle are both honoured.
- Overflow: a FIFO that is full with last_cnt==0 sets ovf_err; that channel deadlocks until reset. The other channel is unaffected. Sequences longer than FIFO_DEPTH are unsupported.
- Result capture:
  - Rising edge of vld_c (previous-cycle register) pushes {res_c, c, id_c} into the result FIFO, then id_c++ (wraps mod 2^ID_WIDTH).
  - Simultaneous edges: ch0 is pushed first, ch1 second, in the same cycle; two write slots are needed.
  - Push with FIFO full: the entry is dropped, drop_err is set, and id still increments.
- Result port: r_* driven from the FIFO head. Values are stable while r_valid & ~r_ready. Pop on r_valid&r_ready. A full FIFO accepts a push in a pop cycle.
- Reset mid-operation: outputs 0 immediately, all in-flight bases and results are discarded.

Test Plan:
1. Config: start pulse at cycle 0 -> ld_p=ld_q=1 in cycle 1 only. sm_ready at cycle 4 -> busy=1 and phase toggling from cycle 5.
2. Single sequence: ch0 bases 10,11,00,01(last) -> en0 high 8 cycles, data_out in ch0 slots = 10,11,00,01, en1=0 throughout.
3. Interleave:
   - Stimulus: ch0 "10,11(last),10(last)" and ch1 "00,00,01(last)".
   - data_out alternates ch0/ch1 bases.
   - en0 drops for exactly one ch0 slot between the two ch0 sequences.
   - en1 spans 6 cycles.
4. Results: vld0 and vld1 rise in the same cycle with res0=0x805, res1=0x803 -> r_* = (0x805, ch0, id 0) then (0x803, ch1, id 0). With r_ready low, the first result is held stable.
5. Backpressure/errors:
   - r_ready low, 5 vld0 edges -> 4 results stored, drop_err=1, next read id sequence 0,1,2,3.
   - 16 ch1 bases without last -> s_ready=0 for ch1, ovf_err=1, ch0 still streams.
6. Async reset: rst low mid-RUN with en0=1 -> en0/en1/ld_*/r_valid 0 without clock edge. After release, FSM is IDLE and FIFOs are empty.

Source files
------------

// File: rtl/sw_target_streamer_if.sv
// Base-intake and tagged-result handshakes between host logic
// and the Smith-Waterman target streamer.
interface sw_target_streamer_if #(
    parameter int SCORE_WIDTH = 12,
    parameter int ID_WIDTH    = 8
);
    logic                   s_valid;
    logic                   s_ready;
    logic [1:0]             s_base;
    logic                   s_chan;
    logic                   s_last;
    logic                   r_valid;
    logic                   r_ready;
    logic [SCORE_WIDTH-1:0] r_score;
    logic                   r_chan;
    logic [ID_WIDTH-1:0]    r_id;

    modport master (
        output s_valid, s_base, s_chan, s_last, r_ready,
        input  s_ready, r_valid, r_score, r_chan, r_id
    );

    modport slave (
        input  s_valid, s_base, s_chan, s_last, r_ready,
        output s_ready, r_valid, r_score, r_chan, r_id
    );
endinterface

// File: rtl/sw_target_streamer.sv
// Host-side streamer for the dual-channel Smith-Waterman array:
// configures it, interleaves target bases, returns tagged scores.
module sw_target_streamer #(
    parameter int SCORE_WIDTH = 12,
    parameter int FIFO_DEPTH  = 16,
    parameter int ID_WIDTH    = 8,
    parameter int RES_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   ld_p,
    output logic                   ld_q,
    input  logic                   sm_ready,
    sw_target_streamer_if.slave    io,
    output logic [1:0]             data_out,
    output logic                   en0_out,
    output logic                   en1_out,
    input  logic [SCORE_WIDTH-1:0] res0_in,
    input  logic [SCORE_WIDTH-1:0] res1_in,
    input  logic                   vld0_in,
    input  logic                   vld1_in,
    output logic                   busy,
    output logic                   ovf_err,
    output logic                   drop_err
);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam int RCW = $clog2(RES_DEPTH + 1);
    localparam int SPW = RCW + 1;
    localparam int RW  = SCORE_WIDTH + 1 + ID_WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RUN} state_t;

    state_t state;
    logic   phase;

    logic [2:0]          bmem [2][FIFO_DEPTH];
    logic [1:0][FAW-1:0] wp, rp;
    logic [1:0][FCW-1:0] cnt, last_cnt;
    logic [1:0]          full, stall, push, pop, pop_last;
    logic [1:0]          active, gap;
    logic [2:0]          head;
    logic                do_pop, do_start, do_gap;

    assign full[0]  = cnt[0] == FCW'(FIFO_DEPTH);
    assign full[1]  = cnt[1] == FCW'(FIFO_DEPTH);
    assign stall[0] = full[0] && (last_cnt[0] == '0);
    assign stall[1] = full[1] && (last_cnt[1] == '0);
    assign io.s_ready = ~full[io.s_chan];
    assign head = bmem[phase][rp[phase]];

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            push[c]     = io.s_valid && io.s_ready && (io.s_chan == 1'(c));
            pop[c]      = do_pop && (phase == 1'(c));
            pop_last[c] = pop[c] && head[0];
        end
    end

    // A sequence only starts once its last base is resident, so pops never underflow.
    always_comb begin
        do_gap   = 1'b0;
        do_pop   = 1'b0;
        do_start = 1'b0;
        if (state == RUN) begin
            if (gap[phase]) begin
                do_gap = 1'b1;
            end else if (active[phase]) begin
                do_pop = 1'b1;
            end else if (last_cnt[phase] != '0) begin
                do_pop   = 1'b1;
                do_start = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (push[c]) bmem[c][wp[c]] <= {io.s_base, io.s_last};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            last_cnt <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                wp[c]       <= wp[c] + FAW'(push[c]);
                rp[c]       <= rp[c] + FAW'(pop[c]);
                cnt[c]      <= cnt[c] + FCW'(push[c]) - FCW'(pop[c]);
                last_cnt[c] <= last_cnt[c] + FCW'(push[c] & io.s_last)
                             - FCW'(pop_last[c]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            phase    <= 1'b0;
            ld_p     <= 1'b0;
            ld_q     <= 1'b0;
            busy     <= 1'b0;
            en0_out  <= 1'b0;
            en1_out  <= 1'b0;
            data_out <= 2'b00;
            active   <= '0;
            gap      <= '0;
            ovf_err  <= 1'b0;
        end else begin
            ld_p  <= 1'b0;
            ld_q  <= 1'b0;
            phase <= (state == RUN) && !phase;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        ld_p  <= 1'b1;
                        ld_q  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                LOAD:    state <= WAIT;
                WAIT:    if (sm_ready) state <= RUN;
                RUN:     state <= RUN;
                default: state <= IDLE;
            endcase
            if (state == RUN) begin
                data_out <= do_pop ? head[2:1] : 2'b00;
                if (phase) en1_out <= do_pop;
                else       en0_out <= do_pop;
                if (do_gap) gap[phase] <= 1'b0;
                if (do_pop && head[0]) begin
                    active[phase] <= 1'b0;
                    gap[phase]    <= 1'b1;
                end else if (do_start) begin
                    active[phase] <= 1'b1;
                end
            end
            if (|stall) ovf_err <= 1'b1;
        end
    end

    logic [1:0]          vld_q, rise;
    logic [ID_WIDTH-1:0] id0, id1;
    logic [RW-1:0]       rmem [RES_DEPTH];
    logic [RAW-1:0]      rwp, rwp2, rrp;
    logic [RCW-1:0]      rcnt;
    logic [SPW-1:0]      space;
    logic                rpop, wr0, wr1;

    assign rise  = {vld1_in & ~vld_q[1], vld0_in & ~vld_q[0]};
    assign rpop  = io.r_valid & io.r_ready;
    assign space = SPW'(RES_DEPTH) - SPW'(rcnt) + SPW'(rpop);
    // ch0 claims the first free slot; ch1 needs one more when both land.
    assign wr0   = rise[0] && (space != '0);
    assign wr1   = rise[1] && (space > SPW'(wr0));
    assign rwp2  = rwp + RAW'(wr0);

    always_ff @(posedge clk) begin
        if (wr0) rmem[rwp]  <= {res0_in, 1'b0, id0};
        if (wr1) rmem[rwp2] <= {res1_in, 1'b1, id1};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q    <= '0;
            id0      <= '0;
            id1      <= '0;
            rwp      <= '0;
            rrp      <= '0;
            rcnt     <= '0;
            drop_err <= 1'b0;
        end else begin
            vld_q <= {vld1_in, vld0_in};
            id0   <= id0 + ID_WIDTH'(rise[0]);
            id1   <= id1 + ID_WIDTH'(rise[1]);
            rwp   <= rwp + RAW'(wr0) + RAW'(wr1);
            rrp   <= rrp + RAW'(rpop);
            rcnt  <= rcnt + RCW'(wr0) + RCW'(wr1) - RCW'(rpop);
            if ((rise[0] && !wr0) || (rise[1] && !wr1)) drop_err <= 1'b1;
        end
    end

    assign io.r_valid = rcnt != '0;
    assign {io.r_score, io.r_chan, io.r_id} = rmem[rrp];
endmodule

// File: tb/tb_sw_target_streamer.sv
// Scoreboard bench for sw_target_streamer: directed base streams
// and result pulses, checked by negedge monitors.
module tb_sw_target_streamer;
    localparam int SW = 12;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          sm_ready = 1'b0;
    logic          vld0_in = 1'b0;
    logic          vld1_in = 1'b0;
    logic [SW-1:0] res0_in = '0;
    logic [SW-1:0] res1_in = '0;
    logic          ld_p, ld_q, en0_out, en1_out;
    logic          busy, ovf_err, drop_err;
    logic [1:0]    data_out;

    sw_target_streamer_if #(.SCORE_WIDTH(SW), .ID_WIDTH(IW)) io ();

    sw_target_streamer #(
        .SCORE_WIDTH(SW), .FIFO_DEPTH(16), .ID_WIDTH(IW), .RES_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .ld_p(ld_p), .ld_q(ld_q), .sm_ready(sm_ready),
        .io(io),
        .data_out(data_out), .en0_out(en0_out), .en1_out(en1_out),
        .res0_in(res0_in), .res1_in(res1_in),
        .vld0_in(vld0_in), .vld1_in(vld1_in),
        .busy(busy), .ovf_err(ovf_err), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic en; logic [1:0] d; } slot_t;
    typedef struct packed { logic [SW-1:0] s; logic c; logic [IW-1:0] id; } res_t;

    slot_t q0[$];
    slot_t q1[$];
    res_t  rq[$];
    int    checks = 0;
    int    errors = 0;
    bit    in_run = 1'b0;
    int    run_t = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_slot(input logic ch, input logic en, input logic [1:0] d);
        slot_t e;
        e = {en, d};
        if (ch) q1.push_back(e);
        else    q0.push_back(e);
    endtask

    task automatic exp_res(input logic [SW-1:0] s, input logic c,
                           input logic [IW-1:0] id);
        res_t e;
        e = {s, c, id};
        rq.push_back(e);
    endtask

    // In RUN cycle t the outputs show the slot of channel (t-1)%2.
    always @(negedge clk) begin : stream_mon
        slot_t got_s, exp_s;
        if (in_run) begin
            if (run_t >= 1) begin
                exp_s = '0;
                if (((run_t - 1) % 2) == 0) begin
                    got_s = {en0_out, data_out};
                    if (q0.size() > 0) exp_s = q0.pop_front();
                    chk("slot_ch0", 32'(got_s), 32'(exp_s));
                end else begin
                    got_s = {en1_out, data_out};
                    if (q1.size() > 0) exp_s = q1.pop_front();
                    chk("slot_ch1", 32'(got_s), 32'(exp_s));
                end
            end
            run_t++;
        end
    end

    always @(negedge clk) begin : res_mon
        res_t got_r, exp_r;
        if (rst && io.r_valid && io.r_ready) begin
            got_r = {io.r_score, io.r_chan, io.r_id};
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL r_unexpected: got %0h expected none", got_r);
            end else begin
                exp_r = rq.pop_front();
                chk("r_entry", 32'(got_r), 32'(exp_r));
            end
        end
    end

    task automatic do_reset();
        in_run = 1'b0;
        run_t = 0;
        q0.delete();
        q1.delete();
        rq.delete();
        start = 1'b0;
        sm_ready = 1'b0;
        vld0_in = 1'b0;
        vld1_in = 1'b0;
        io.s_valid = 1'b0;
        io.s_last = 1'b0;
        io.s_chan = 1'b0;
        io.r_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_outs", {ld_p, ld_q, busy, en0_out, en1_out, data_out,
                         io.r_valid, ovf_err, drop_err}, 0);
        chk("rst_s_ready", io.s_ready, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic cfg();
        chk("idle_busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ld_pulse", {ld_p, ld_q, busy}, 3'b111);
        tick();
        chk("ld_end", {ld_p, ld_q, busy}, 3'b001);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wait_ignore_start", {ld_p, ld_q, busy, en0_out, en1_out}, 5'b00100);
    endtask

    task automatic push_base(input logic ch, input logic [1:0] b, input logic last);
        io.s_valid = 1'b1;
        io.s_chan = ch;
        io.s_base = b;
        io.s_last = last;
        #1 chk("s_ready", io.s_ready, 1);
        tick();
        io.s_valid = 1'b0;
        io.s_last = 1'b0;
    endtask

    task automatic go();
        sm_ready = 1'b1;
        tick();
        in_run = 1'b1;
        run_t = 0;
    endtask

    task automatic run(input int n, output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        repeat (n) begin
            tick();
            c0 += int'(en0_out);
            c1 += int'(en1_out);
        end
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        while (rq.size() != 0 && n < lim) begin
            tick();
            n++;
        end
        chk("r_drain_left", rq.size(), 0);
    endtask

    task automatic vld0_edge(input logic [SW-1:0] v);
        vld0_in = 1'b1;
        res0_in = v;
        tick();
        vld0_in = 1'b0;
        tick();
    endtask

    initial begin
        int c0, c1, mcnt;
        io.s_valid = 1'b0;
        io.s_base = 2'b00;
        io.s_chan = 1'b0;
        io.s_last = 1'b0;
        io.r_ready = 1'b0;

        // config + single ch0 sequence
        do_reset();
        cfg();
        push_base(0, 2'b10, 0);
        push_base(0, 2'b11, 0);
        push_base(0, 2'b00, 0);
        push_base(0, 2'b01, 1);
        exp_slot(0, 1, 2'b10);
        exp_slot(0, 1, 2'b11);
        exp_slot(0, 1, 2'b00);
        exp_slot(0, 1, 2'b01);
        exp_slot(0, 0, 2'b00);
        go();
        run(20, c0, c1);
        chk("seq_en0_cycles", c0, 8);
        chk("seq_en1_cycles", c1, 0);
        chk("seq_q0_left", q0.size(), 0);

        // interleaved channels with back-to-back ch0 sequences
        do_reset();
        cfg();
        push_base(0, 2'b10, 0);
        push_base(1, 2'b00, 0);
        push_base(0, 2'b11, 1);
        push_base(1, 2'b00, 0);
        push_base(0, 2'b10, 1);
        push_base(1, 2'b01, 1);
        exp_slot(0, 1, 2'b10);
        exp_slot(0, 1, 2'b11);
        exp_slot(0, 0, 2'b00);
        exp_slot(0, 1, 2'b10);
        exp_slot(0, 0, 2'b00);
        exp_slot(1, 1, 2'b00);
        exp_slot(1, 1, 2'b00);
        exp_slot(1, 1, 2'b01);
        exp_slot(1, 0, 2'b00);
        go();
        run(24, c0, c1);
        chk("il_en0_cycles", c0, 6);
        chk("il_en1_cycles", c1, 6);
        chk("il_q_left", q0.size() + q1.size(), 0);

        // simultaneous result edges, head held under backpressure
        do_reset();
        exp_res(12'h805, 1'b0, 8'd0);
        exp_res(12'h803, 1'b1, 8'd0);
        vld0_in = 1'b1;
        vld1_in = 1'b1;
        res0_in = 12'h805;
        res1_in = 12'h803;
        tick();
        vld0_in = 1'b0;
        vld1_in = 1'b0;
        repeat (3) begin
            chk("r_hold", {io.r_valid, io.r_score, io.r_chan, io.r_id},
                {1'b1, 12'h805, 1'b0, 8'd0});
            tick();
        end
        io.r_ready = 1'b1;
        drain(10);
        io.r_ready = 1'b0;
        chk("r_empty", io.r_valid, 0);

        // result FIFO overflow, then push into a full FIFO on a pop cycle
        do_reset();
        mcnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk("drop_before", drop_err, 0);
            if (mcnt < 4) begin
                exp_res(12'(32'h100 + i), 1'b0, 8'(i));
                mcnt++;
            end
            vld0_edge(12'(32'h100 + i));
        end
        chk("drop_err", drop_err, 1);
        chk("full_valid", io.r_valid, 1);
        io.r_ready = 1'b1;
        vld0_in = 1'b1;
        res0_in = 12'h1AB;
        exp_res(12'h1AB, 1'b0, 8'd5);
        tick();
        vld0_in = 1'b0;
        drain(20);
        io.r_ready = 1'b0;
        chk("drop_empty", io.r_valid, 0);

        // ch1 overflow while ch0 keeps streaming
        do_reset();
        cfg();
        for (int i = 0; i < 12; i++) begin
            push_base(0, 2'(i), i == 11);
            exp_slot(0, 1, 2'(i));
        end
        exp_slot(0, 0, 2'b00);
        go();
        for (int i = 0; i < 16; i++) push_base(1, 2'b00, 0);
        io.s_chan = 1'b1;
        #1 chk("ovf_s_ready_ch1", io.s_ready, 0);
        tick();
        chk("ovf_err", ovf_err, 1);
        io.s_chan = 1'b0;
        #1 chk("ovf_s_ready_ch0", io.s_ready, 1);
        chk("ovf_ch0_streams", en0_out, 1);
        run(20, c0, c1);
        chk("ovf_q0_left", q0.size(), 0);
        chk("ovf_en1_cycles", c1, 0);

        // asynchronous reset mid-run
        do_reset();
        cfg();
        push_base(0, 2'b11, 0);
        push_base(0, 2'b10, 0);
        push_base(0, 2'b01, 1);
        exp_slot(0, 1, 2'b11);
        exp_slot(0, 1, 2'b10);
        exp_slot(0, 1, 2'b01);
        vld0_edge(12'h0AA);
        go();
        tick();
        tick();
        chk("pre_rst_en0", en0_out, 1);
        chk("pre_rst_rvalid", io.r_valid, 1);
        do_reset();
        chk("post_rst_busy", busy, 0);
        io.s_chan = 1'b1;
        #1 chk("post_rst_ready1", io.s_ready, 1);
        cfg();
        go();
        run(12, c0, c1);
        chk("post_rst_en0", c0, 0);
        chk("post_rst_en1", c1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
